// File: rtl/control_path_pkg.sv
// control_path_pkg -- shared definitions for the control_path block.
//   State encodings, opcode constants, opcode classes, reg_write/op_select
//   codes and IR field bit ranges, plus the opcode classifier.
package control_path_pkg;

  typedef enum logic [4:0] {
    S_HALT       = 5'b00000,
    S_READ_INS   = 5'b01000,
    S_DO         = 5'b01001,
    S_WAIT_LOAD  = 5'b01010,
    S_WAIT_STORE = 5'b01100,
    S_TRAP       = 5'b10000
  } state_e;

  localparam logic [2:0] OP_HALT = 3'b000;
  localparam logic [2:0] OP_LD   = 3'b001;
  localparam logic [2:0] OP_ST   = 3'b010;
  localparam logic [2:0] OP_NOP  = 3'b011;
  localparam logic [2:0] OP_ALU0 = 3'b100;
  localparam logic [2:0] OP_ALU1 = 3'b101;
  localparam logic [2:0] OP_ALU2 = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [2:0] {
    CLS_HALT,
    CLS_LD,
    CLS_ST,
    CLS_NOP,
    CLS_ALU_Y12,  // ALU writing both Y1 and Y2
    CLS_ALU_Y1,   // ALU writing Y1 only
    CLS_RSVD
  } op_class_e;

  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_Y1   = 2'b01;
  localparam logic [1:0] RW_Y12  = 2'b11;

  localparam logic [3:0] OPS_NONE = 4'b0000;
  localparam logic [3:0] OPS_ALU  = 4'b0001;
  localparam logic [3:0] OPS_LOAD = 4'b0010;

  // IR field bit ranges
  localparam int OPC_MSB = 31, OPC_LSB = 29;
  localparam int CONSTC_BIT = 28;
  localparam int CFG_MSB = 27, CFG_LSB = 24;
  localparam int Y2_MSB  = 23, Y2_LSB  = 20;
  localparam int Y1_MSB  = 19, Y1_LSB  = 16;
  localparam int A_MSB   = 15, A_LSB   = 12;
  localparam int B_MSB   = 11, B_LSB   = 8;
  localparam int C_MSB   = 7,  C_LSB   = 4;
  localparam int D_MSB   = 3,  D_LSB   = 0;

  function automatic op_class_e classify(input logic [2:0] opc);
    case (opc)
      OP_HALT: return CLS_HALT;
      OP_LD:   return CLS_LD;
      OP_ST:   return CLS_ST;
      OP_NOP:  return CLS_NOP;
      OP_ALU0: return CLS_ALU_Y12;
      OP_ALU1: return CLS_ALU_Y12;
      OP_ALU2: return CLS_ALU_Y1;
      default: return CLS_RSVD;
    endcase
  endfunction

endpackage

// File: rtl/control_path_decode.sv
// control_path_decode -- combinational IR field extraction.
//   i_ir            : instruction register contents
//   o_opcode..o_d   : IR fields driven straight to the datapath selects
//   o_mem_loca_addr : memory address register select (IR[11:8])
//   o_reg_addr      : load destination / store source (IR[15:12])
//   o_cls           : opcode class consumed by the FSM
module control_path_decode
  import control_path_pkg::*;
(
  input  logic [31:0] i_ir,
  output logic [2:0]  o_opcode,
  output logic        o_alu_form,
  output logic [1:0]  o_alu_vec_perci,
  output logic [3:0]  o_alu_config,
  output logic        o_const_c,
  output logic [3:0]  o_a_select,
  output logic [3:0]  o_b_select,
  output logic [3:0]  o_c_select,
  output logic [3:0]  o_d_select,
  output logic [3:0]  o_y1_select,
  output logic [3:0]  o_y2_select,
  output logic [3:0]  o_mem_loca_addr,
  output logic [3:0]  o_reg_addr,
  output op_class_e   o_cls
);

  logic [2:0] w_opc;
  assign w_opc = i_ir[OPC_MSB:OPC_LSB];

  assign o_opcode        = w_opc;
  assign o_alu_form      = w_opc[0];
  assign o_alu_vec_perci = w_opc[2:1];
  assign o_alu_config    = i_ir[CFG_MSB:CFG_LSB];
  assign o_const_c       = i_ir[CONSTC_BIT];
  assign o_a_select      = i_ir[A_MSB:A_LSB];
  assign o_b_select      = i_ir[B_MSB:B_LSB];
  assign o_c_select      = i_ir[C_MSB:C_LSB];
  assign o_d_select      = i_ir[D_MSB:D_LSB];
  assign o_y1_select     = i_ir[Y1_MSB:Y1_LSB];
  assign o_y2_select     = i_ir[Y2_MSB:Y2_LSB];
  // Memory address and register share bit positions with B and A selects.
  assign o_mem_loca_addr = i_ir[B_MSB:B_LSB];
  assign o_reg_addr      = i_ir[A_MSB:A_LSB];
  assign o_cls           = classify(w_opc);

endmodule

// File: rtl/control_path.sv
// control_path -- multi-cycle fetch/decode/execute control FSM.
//   clk, resetn (sync, active low), go (sampled in HALT only)
//   instruction, wait_instr, instr_segv : fetch port
//   wait_data, data_segv                : data port
//   pc_inc, reg_write, op_select, ld, st: enables
//   opcode .. reg_addr                  : IR fields (always reflect IR)
// Build option: define CONTROLPATH_TRAP_EN to trap on segv inputs and on the
// reserved opcode. Without it, segv is ignored, the reserved opcode runs as a
// NOP and TRAP cannot be entered.
module control_path
  import control_path_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        go,
  input  logic [31:0] instruction,
  input  logic        instr_segv,
  input  logic        data_segv,
  input  logic        wait_instr,
  input  logic        wait_data,
  output logic        pc_inc,
  output logic [2:0]  opcode,
  output logic        alu_form,
  output logic [1:0]  alu_vec_perci,
  output logic [3:0]  alu_config,
  output logic        const_c,
  output logic [3:0]  a_select,
  output logic [3:0]  alu_b_select,
  output logic [3:0]  alu_c_select,
  output logic [3:0]  alu_d_select,
  output logic [3:0]  alu_Y1_select,
  output logic [3:0]  alu_Y2_select,
  output logic [1:0]  reg_write,
  output logic [3:0]  op_select,
  output logic [3:0]  mem_loca_addr,
  output logic [3:0]  reg_addr,
  output logic        ld,
  output logic        st
);

  // Initialisers make the block come up in HALT with IR clear even when
  // resetn is never asserted.
  state_e      r_current_state = S_HALT;
  logic [31:0] r_ir = '0;
  op_class_e   w_cls;
  logic        w_isegv, w_dsegv;

`ifdef CONTROLPATH_TRAP_EN
  assign w_isegv = instr_segv;
  assign w_dsegv = data_segv;
`else
  logic w_segv_unused;
  assign w_segv_unused = instr_segv ^ data_segv;
  assign w_isegv = 1'b0;
  assign w_dsegv = 1'b0;
`endif

  control_path_decode u_decode (
    .i_ir            (r_ir),
    .o_opcode        (opcode),
    .o_alu_form      (alu_form),
    .o_alu_vec_perci (alu_vec_perci),
    .o_alu_config    (alu_config),
    .o_const_c       (const_c),
    .o_a_select      (a_select),
    .o_b_select      (alu_b_select),
    .o_c_select      (alu_c_select),
    .o_d_select      (alu_d_select),
    .o_y1_select     (alu_Y1_select),
    .o_y2_select     (alu_Y2_select),
    .o_mem_loca_addr (mem_loca_addr),
    .o_reg_addr      (reg_addr),
    .o_cls           (w_cls)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_current_state <= S_HALT;
      r_ir            <= '0;
    end else begin
      case (r_current_state)
        S_HALT:
          if (go) r_current_state <= S_READ_INS;
        S_READ_INS:
          // segv beats wait
          if (w_isegv) r_current_state <= S_TRAP;
          else if (!wait_instr) begin
            r_ir            <= instruction;
            r_current_state <= S_DO;
          end
        S_DO:
          case (w_cls)
            CLS_LD:   r_current_state <= S_WAIT_LOAD;
            CLS_ST:   r_current_state <= S_WAIT_STORE;
            CLS_HALT: r_current_state <= S_HALT;
`ifdef CONTROLPATH_TRAP_EN
            CLS_RSVD: r_current_state <= S_TRAP;
`endif
            default:  r_current_state <= S_READ_INS;
          endcase
        S_WAIT_LOAD, S_WAIT_STORE:
          if (w_dsegv) r_current_state <= S_TRAP;
          else if (!wait_data) r_current_state <= S_READ_INS;
        S_TRAP:
          r_current_state <= S_TRAP;
        default:
          r_current_state <= S_HALT;
      endcase
    end
  end

  // Enables: Moore on state/IR, except the WAIT exits which look at wait_data
  // so the write-back and PC advance line up with the memory handshake.
  always_comb begin
    pc_inc    = 1'b0;
    reg_write = RW_NONE;
    op_select = OPS_NONE;
    ld        = 1'b0;
    st        = 1'b0;
    case (r_current_state)
      S_DO:
        case (w_cls)
          CLS_ALU_Y12: begin
            reg_write = RW_Y12;
            op_select = OPS_ALU;
            pc_inc    = 1'b1;
          end
          CLS_ALU_Y1: begin
            reg_write = RW_Y1;
            op_select = OPS_ALU;
            pc_inc    = 1'b1;
          end
          CLS_NOP: pc_inc = 1'b1;
`ifndef CONTROLPATH_TRAP_EN
          CLS_RSVD: pc_inc = 1'b1;
`endif
          CLS_LD: ld = 1'b1;
          CLS_ST: st = 1'b1;
          default: ;
        endcase
      S_WAIT_LOAD: begin
        ld = 1'b1;
        if (!w_dsegv && !wait_data) begin
          reg_write = RW_Y1;
          op_select = OPS_LOAD;
          pc_inc    = 1'b1;
        end
      end
      S_WAIT_STORE: begin
        st = 1'b1;
        if (!w_dsegv && !wait_data) pc_inc = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_path.sv
module tb_control_path;

`ifdef CONTROLPATH_TRAP_EN
  localparam bit T = 1'b1;
`else
  localparam bit T = 1'b0;
`endif

  localparam logic [4:0] HALT = 5'b00000, RI = 5'b01000, DO = 5'b01001,
                         WL = 5'b01010, WS = 5'b01100, TRAP = 5'b10000;

  typedef struct packed {
    logic rst, go, isegv, dsegv, wi, wd;
    logic [31:0] ins;
  } stim_t;

  typedef struct packed {
    logic [4:0] st;
    logic       pc;
    logic [1:0] rw;
    logic [3:0] ops;
    logic       ld, stq;
  } ctl_t;

  typedef struct packed {
    stim_t       s;
    ctl_t        e;
    logic        fchk;
    logic [42:0] f;
  } row_t;

  logic        clk, resetn, go, instr_segv, data_segv, wait_instr, wait_data;
  logic [31:0] instruction;
  logic        pc_inc, alu_form, const_c, ld, st;
  logic [2:0]  opcode;
  logic [1:0]  alu_vec_perci, reg_write;
  logic [3:0]  alu_config, a_select, alu_b_select, alu_c_select, alu_d_select;
  logic [3:0]  alu_Y1_select, alu_Y2_select, op_select, mem_loca_addr, reg_addr;

  int   n_chk = 0, n_pass = 0;
  row_t exp_q[$];

  control_path dut (
    .clk(clk), .resetn(resetn), .go(go), .instruction(instruction),
    .instr_segv(instr_segv), .data_segv(data_segv),
    .wait_instr(wait_instr), .wait_data(wait_data),
    .pc_inc(pc_inc), .opcode(opcode), .alu_form(alu_form),
    .alu_vec_perci(alu_vec_perci), .alu_config(alu_config), .const_c(const_c),
    .a_select(a_select), .alu_b_select(alu_b_select),
    .alu_c_select(alu_c_select), .alu_d_select(alu_d_select),
    .alu_Y1_select(alu_Y1_select), .alu_Y2_select(alu_Y2_select),
    .reg_write(reg_write), .op_select(op_select),
    .mem_loca_addr(mem_loca_addr), .reg_addr(reg_addr), .ld(ld), .st(st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t S(logic rst, logic g, logic is, logic ds,
                              logic wi, logic wd, logic [31:0] ins);
    return '{rst, g, is, ds, wi, wd, ins};
  endfunction

  function automatic ctl_t C(logic [4:0] s, logic pc, logic [1:0] rw,
                             logic [3:0] ops, logic l, logic sq);
    return '{s, pc, rw, ops, l, sq};
  endfunction

  function automatic row_t R(stim_t s, ctl_t e, logic fc = 1'b0,
                             logic [42:0] f = '0);
    return '{s, e, fc, f};
  endfunction

  // Expected field bundle, built from the ISA field positions.
  function automatic logic [42:0] fld(logic [31:0] ir);
    return {ir[31:29], ir[29], ir[31:30], ir[27:24], ir[28], ir[15:12],
            ir[11:8], ir[7:4], ir[3:0], ir[19:16], ir[23:20], ir[11:8],
            ir[15:12]};
  endfunction

  task automatic drive(stim_t s);
    resetn      = s.rst;
    go          = s.go;
    instr_segv  = s.isegv;
    data_segv   = s.dsegv;
    wait_instr  = s.wi;
    wait_data   = s.wd;
    instruction = s.ins;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    drive(S(0, 0, 0, 0, 0, 0, 32'h0));
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  function automatic ctl_t obs_ctl();
    return {dut.r_current_state, pc_inc, reg_write, op_select, ld, st};
  endfunction

  function automatic logic [42:0] obs_fld();
    return {opcode, alu_form, alu_vec_perci, alu_config, const_c, a_select,
            alu_b_select, alu_c_select, alu_d_select, alu_Y1_select,
            alu_Y2_select, mem_loca_addr, reg_addr};
  endfunction

  localparam logic [31:0] I_ALU = 32'h80801234;
  localparam logic [31:0] I_LD  = 32'h20001200;
  localparam logic [31:0] I_ST  = 32'h40000000;
  localparam logic [31:0] I_RSV = 32'hE0000000;
  localparam logic [42:0] F_ALU = {3'b100, 1'b0, 2'b10, 4'h0, 1'b0, 4'h1, 4'h2,
                                   4'h3, 4'h4, 4'h0, 4'h8, 4'h2, 4'h1};
  localparam logic [42:0] F_LD  = {3'b001, 1'b1, 2'b00, 4'h0, 1'b0, 4'h1, 4'h2,
                                   4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h1};

  task automatic test_noreset();
    row_t rows[$];
    row_t e;
    for (int i = 0; i < 10; i++)
      rows.push_back(R(S(1, 0, 0, 0, 0, 0, 0), C(HALT, 0, 0, 0, 0, 0), 1, '0));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #1; drive(rows[i].s); exp_q.push_back(rows[i]);
      @(negedge clk); e = exp_q.pop_front();
      n_chk++;
      if (obs_ctl() !== e.e) $display("FAIL noreset[%0d] ctl got %h want %h", i, obs_ctl(), e.e);
      else n_pass++;
      n_chk++;
      if (obs_fld() !== e.f) $display("FAIL noreset[%0d] fld got %h want %h", i, obs_fld(), e.f);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    row_t rows[$];
    row_t e;
    rows.push_back(R(S(1, 1, 0, 0, 0, 0, I_ALU), C(HALT, 0, 0, 0, 0, 0)));
    rows.push_back(R(S(1, 0, 0, 0, 0, 0, I_ALU), C(RI, 0, 0, 0, 0, 0)));
    rows.push_back(R(S(0, 0, 0, 0, 0, 0, I_ALU), C(DO, 1, 2'b11, 4'b0001, 0, 0), 1, F_ALU));
    rows.push_back(R(S(1, 0, 0, 0, 0, 0, I_ALU), C(HALT, 0, 0, 0, 0, 0), 1, '0));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #1; drive(rows[i].s); exp_q.push_back(rows[i]);
      @(negedge clk); e = exp_q.pop_front();
      n_chk++;
      if (obs_ctl() !== e.e) $display("FAIL reset[%0d] ctl got %h want %h", i, obs_ctl(), e.e);
      else n_pass++;
      if (e.fchk) begin
        n_chk++;
        if (obs_fld() !== e.f) $display("FAIL reset[%0d] fld got %h want %h", i, obs_fld(), e.f);
        else n_pass++;
      end
    end
  endtask

  task automatic test_alu();
    row_t rows[$];
    row_t e;
    do_reset();
    rows.push_back(R(S(1, 1, 0, 0, 1, 0, I_ALU), C(HALT, 0, 0, 0, 0, 0)));
    rows.push_back(R(S(1, 0, 0, 0, 1, 0, I_ALU), C(RI, 0, 0, 0, 0, 0)));
    rows.push_back(R(S(1, 0, 0, 0, 0, 0, I_ALU), C(RI, 0, 0, 0, 0, 0)));
    rows.push_back(R(S(1, 0, 0, 0, 1, 0, 0), C(DO, 1, 2'b11, 4'b0001, 0, 0), 1, F_ALU));
    rows.push_back(R(S(1, 0, 0, 0, 1, 0, 0), C(RI, 0, 0, 0, 0, 0), 1, F_ALU));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #1; drive(rows[i].s); exp_q.push_back(rows[i]);
      @(negedge clk); e = exp_q.pop_front();
      n_chk++;
      if (obs_ctl() !== e.e) $display("FAIL alu[%0d] ctl got %h want %h", i, obs_ctl(), e.e);
      else n_pass++;
      if (e.fchk) begin
        n_chk++;
        if (obs_fld() !== e.f) $display("FAIL alu[%0d] fld got %h want %h", i, obs_fld(), e.f);
        else n_pass++;
      end
    end
  endtask

  task automatic test_load_wait();
    row_t rows[$];
    row_t e;
    do_reset();
    rows.push_back(R(S(1, 1, 0, 0, 1, 0, 0), C(HALT, 0, 0, 0, 0, 0)));
    rows.push_back(R(S(1, 0, 0, 0, 0, 0, I_LD), C(RI, 0, 0, 0, 0, 0)));
    rows.push_back(R(S(1, 0, 0, 0, 1, 1, 0), C(DO, 0, 0, 0, 1, 0), 1, F_LD));
    for (int k = 0; k < 3; k++)
      rows.push_back(R(S(1, 0, 0, 0, 1, 1, 0), C(WL, 0, 0, 0, 1, 0), 1, F_LD));
    rows.push_back(R(S(1, 0, 0, 0, 1, 0, 0), C(WL, 1, 2'b01, 4'b0010, 1, 0), 1, F_LD));
    rows.push_back(R(S(1, 0, 0, 0, 1, 0, 0), C(RI, 0, 0, 0, 0, 0)));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #1; drive(rows[i].s); exp_q.push_back(rows[i]);
      @(negedge clk); e = exp_q.pop_front();
      n_chk++;
      if (obs_ctl() !== e.e) $display("FAIL load[%0d] ctl got %h want %h", i, obs_ctl(), e.e);
      else n_pass++;
      if (e.fchk) begin
        n_chk++;
        if (obs_fld() !== e.f) $display("FAIL load[%0d] fld got %h want %h", i, obs_fld(), e.f);
        else n_pass++;
      end
    end
  endtask

  task automatic test_store_segv();
    row_t rows[$];
    row_t e;
    ctl_t after;
    do_reset();
    after = T ? C(TRAP, 0, 0, 0, 0, 0) : C(RI, 0, 0, 0, 0, 0);
    rows.push_back(R(S(1, 1, 0, 0, 1, 0, 0), C(HALT, 0, 0, 0, 0, 0)));
    rows.push_back(R(S(1, 0, 0, 0, 0, 0, I_ST), C(RI, 0, 0, 0, 0, 0)));
    rows.push_back(R(S(1, 0, 0, 1, 1, 0, 0), C(DO, 0, 0, 0, 0, 1)));
    rows.push_back(R(S(1, 0, 0, 1, 1, 1, 0), C(WS, 0, 0, 0, 0, 1)));
    rows.push_back(R(S(1, 0, 0, 1, 1, 0, 0),
                     T ? C(TRAP, 0, 0, 0, 0, 0) : C(WS, 1, 0, 0, 0, 1)));
    rows.push_back(R(S(1, 1, 0, 0, 1, 0, 0), after));
    rows.push_back(R(S(1, 0, 0, 0, 1, 0, 0), after));
    rows.push_back(R(S(1, 1, 0, 0, 1, 0, 0), after));
    rows.push_back(R(S(0, 0, 0, 0, 1, 0, 0), after));
    rows.push_back(R(S(1, 0, 0, 0, 1, 0, 0), C(HALT, 0, 0, 0, 0, 0)));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #1; drive(rows[i].s); exp_q.push_back(rows[i]);
      @(negedge clk); e = exp_q.pop_front();
      n_chk++;
      if (obs_ctl() !== e.e) $display("FAIL store_segv[%0d] ctl got %h want %h", i, obs_ctl(), e.e);
      else n_pass++;
    end
  endtask

  task automatic test_instr_segv();
    row_t rows[$];
    row_t e;
    do_reset();
    rows.push_back(R(S(1, 1, 0, 0, 1, 0, 0), C(HALT, 0, 0, 0, 0, 0)));
    rows.push_back(R(S(1, 0, 1, 0, 0, 0, I_ALU), C(RI, 0, 0, 0, 0, 0)));
    rows.push_back(R(S(1, 0, 0, 0, 1, 0, 0),
                     T ? C(TRAP, 0, 0, 0, 0, 0) : C(DO, 1, 2'b11, 4'b0001, 0, 0)));
    rows.push_back(R(S(1, 1, 0, 0, 1, 0, 0),
                     T ? C(TRAP, 0, 0, 0, 0, 0) : C(RI, 0, 0, 0, 0, 0)));
    rows.push_back(R(S(1, 0, 0, 0, 1, 0, 0),
                     T ? C(TRAP, 0, 0, 0, 0, 0) : C(RI, 0, 0, 0, 0, 0)));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #1; drive(rows[i].s); exp_q.push_back(rows[i]);
      @(negedge clk); e = exp_q.pop_front();
      n_chk++;
      if (obs_ctl() !== e.e) $display("FAIL instr_segv[%0d] ctl got %h want %h", i, obs_ctl(), e.e);
      else n_pass++;
    end
  endtask

  task automatic test_reserved();
    row_t rows[$];
    row_t e;
    do_reset();
    rows.push_back(R(S(1, 1, 0, 0, 1, 0, 0), C(HALT, 0, 0, 0, 0, 0)));
    rows.push_back(R(S(1, 0, 0, 0, 0, 0, I_RSV), C(RI, 0, 0, 0, 0, 0)));
    rows.push_back(R(S(1, 0, 0, 0, 1, 0, 0), C(DO, !T, 0, 0, 0, 0)));
    rows.push_back(R(S(1, 0, 0, 0, 1, 0, 0),
                     T ? C(TRAP, 0, 0, 0, 0, 0) : C(RI, 0, 0, 0, 0, 0)));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #1; drive(rows[i].s); exp_q.push_back(rows[i]);
      @(negedge clk); e = exp_q.pop_front();
      n_chk++;
      if (obs_ctl() !== e.e) $display("FAIL reserved[%0d] ctl got %h want %h", i, obs_ctl(), e.e);
      else n_pass++;
    end
  endtask

  task automatic test_halt_op();
    row_t rows[$];
    row_t e;
    do_reset();
    rows.push_back(R(S(1, 1, 0, 0, 1, 0, 0), C(HALT, 0, 0, 0, 0, 0)));
    rows.push_back(R(S(1, 0, 0, 0, 0, 0, 32'h0), C(RI, 0, 0, 0, 0, 0)));
    rows.push_back(R(S(1, 0, 0, 0, 1, 0, 0), C(DO, 0, 0, 0, 0, 0)));
    rows.push_back(R(S(1, 0, 0, 0, 1, 0, 0), C(HALT, 0, 0, 0, 0, 0)));
    rows.push_back(R(S(1, 1, 0, 0, 1, 0, 0), C(HALT, 0, 0, 0, 0, 0)));
    rows.push_back(R(S(1, 0, 0, 0, 1, 0, 0), C(RI, 0, 0, 0, 0, 0)));
    rows.push_back(R(S(1, 0, 0, 0, 1, 0, 0), C(RI, 0, 0, 0, 0, 0)));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #1; drive(rows[i].s); exp_q.push_back(rows[i]);
      @(negedge clk); e = exp_q.pop_front();
      n_chk++;
      if (obs_ctl() !== e.e) $display("FAIL halt_op[%0d] ctl got %h want %h", i, obs_ctl(), e.e);
      else n_pass++;
    end
  endtask

  // Zero-wait ALU stream: each instruction occupies exactly READ_INS + DO.
  task automatic test_back_to_back();
    row_t rows[$];
    row_t e;
    logic [31:0] ins;
    logic [2:0]  opc;
    do_reset();
    rows.push_back(R(S(1, 1, 0, 0, 1, 0, 0), C(HALT, 0, 0, 0, 0, 0)));
    for (int k = 0; k < 8; k++) begin
      opc = 3'($urandom_range(4, 6));
      ins = {opc, 29'($urandom)};
      rows.push_back(R(S(1, 0, 0, 0, 0, 0, ins), C(RI, 0, 0, 0, 0, 0)));
      rows.push_back(R(S(1, 0, 0, 0, 1, 0, 0),
                       C(DO, 1, (opc == 3'b110) ? 2'b01 : 2'b11, 4'b0001, 0, 0),
                       1, fld(ins)));
    end
    rows.push_back(R(S(1, 0, 0, 0, 1, 0, 0), C(RI, 0, 0, 0, 0, 0)));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #1; drive(rows[i].s); exp_q.push_back(rows[i]);
      @(negedge clk); e = exp_q.pop_front();
      n_chk++;
      if (obs_ctl() !== e.e) $display("FAIL b2b[%0d] ctl got %h want %h", i, obs_ctl(), e.e);
      else n_pass++;
      if (e.fchk) begin
        n_chk++;
        if (obs_fld() !== e.f) $display("FAIL b2b[%0d] fld got %h want %h", i, obs_fld(), e.f);
        else n_pass++;
      end
    end
  endtask

  initial begin
    drive(S(1, 0, 0, 0, 0, 0, 32'h0));
    test_noreset();
    test_reset();
    test_alu();
    test_load_wait();
    test_store_segv();
    test_instr_segv();
    test_reserved();
    test_halt_op();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
